// File: rtl/meas_sequencer.sv
// meas_sequencer
//   Sequences one frequency measurement for the 7-segment display path.
//   IN is synchronised and edge-detected; rising edges are counted during a
//   fixed gate window, the saturated count is latched for the display stage,
//   and then held for a display-stable interval before the next window.
//
// Ports
//   CLK        system clock (100 MHz)
//   reset      synchronous, active-high reset
//   IN         asynchronous signal under measurement
//   run        level: windows repeat back-to-back while high
//   single     one-cycle pulse: request one window when idle
//   freq       last latched edge count (CNT_W bits)
//   freq_valid one-cycle pulse when freq/overflow update
//   overflow   last latched window saturated at MAX_COUNT
//   busy       high in every state except IDLE
//   gate       high exactly while the gate window is open
module meas_sequencer #(
  parameter int GATE_CYCLES = 100000000,
  parameter int HOLD_CYCLES = 50000000,
  parameter int CNT_W       = 14,
  parameter int MAX_COUNT   = 9999
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             IN,
  input  logic             run,
  input  logic             single,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             busy,
  output logic             gate
);

  localparam int TIMER_MAX = (GATE_CYCLES > HOLD_CYCLES) ? GATE_CYCLES : HOLD_CYCLES;
  // One spare bit so the terminal value never wraps inside a state.
  localparam int TIMER_W = $clog2(TIMER_MAX) + 1;

  localparam logic [TIMER_W-1:0] GATE_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   MAX_CNT   = CNT_W'(MAX_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_LATCH,
    ST_HOLD
  } state_t;

  state_t             state;
  logic [TIMER_W-1:0] timer;
  logic [CNT_W-1:0]   edge_cnt;
  logic               ovf_flag;
  logic               s1;
  logic               s2;
  logic               s3;
  logic               rise;

  // s1/s2 resolve metastability; s3 is only a delayed copy for edge detection.
  assign rise = s2 & ~s3;

  assign busy = (state != ST_IDLE);
  assign gate = (state == ST_GATE);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state      <= ST_IDLE;
      timer      <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      freq       <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      s1         <= IN;
      s2         <= s1;
      s3         <= s2;
      freq_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (run | single) begin
            state    <= ST_GATE;
            edge_cnt <= '0;
            ovf_flag <= 1'b0;
            timer    <= '0;
          end
        end

        ST_GATE: begin
          // Saturate at the largest displayable value and remember that we did.
          if (rise) begin
            if (edge_cnt < MAX_CNT) begin
              edge_cnt <= edge_cnt + 1'b1;
            end else begin
              ovf_flag <= 1'b1;
            end
          end
          if (timer == GATE_LAST) begin
            state <= ST_LATCH;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_LATCH: begin
          // A rise seen here falls outside the window and is deliberately dropped.
          freq       <= edge_cnt;
          overflow   <= ovf_flag;
          freq_valid <= 1'b1;
          timer      <= '0;
          state      <= ST_HOLD;
        end

        ST_HOLD: begin
          // run is only looked at here, so dropping it never cuts a window short.
          if (timer == HOLD_LAST) begin
            if (run) begin
              state    <= ST_GATE;
              edge_cnt <= '0;
              ovf_flag <= 1'b0;
              timer    <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meas_sequencer.sv
// tb_meas_sequencer
//   Scoreboard bench for meas_sequencer with a short gate (100), hold (10) and
//   saturation value (20). Each window pushes its hand-computed result; the
//   monitor pops and compares on every freq_valid pulse.
module tb_meas_sequencer;

  localparam int GATE_CYCLES = 100;
  localparam int HOLD_CYCLES = 10;
  localparam int CNT_W       = 14;
  localparam int MAX_COUNT   = 20;

  typedef struct packed {
    logic             ovf;
    logic [CNT_W-1:0] f;
  } sb_entry_t;

  logic             CLK;
  logic             reset;
  logic             IN;
  logic             run;
  logic             single;
  logic [CNT_W-1:0] freq;
  logic             freq_valid;
  logic             overflow;
  logic             busy;
  logic             gate;

  sb_entry_t sb_q[$];
  sb_entry_t mon_exp;
  int        total;
  int        bad;

  meas_sequencer #(
    .GATE_CYCLES(GATE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .CNT_W      (CNT_W),
    .MAX_COUNT  (MAX_COUNT)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .IN        (IN),
    .run       (run),
    .single    (single),
    .freq      (freq),
    .freq_valid(freq_valid),
    .overflow  (overflow),
    .busy      (busy),
    .gate      (gate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every freq_valid pulse must match the oldest pending window result.
  always @(negedge CLK) begin
    if (!reset && freq_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got pulse with freq=%0d overflow=%0d, expected none",
                 freq, overflow);
      end else begin
        mon_exp = sb_q.pop_front();
        checkOutput("sb_freq", int'(freq), int'(mon_exp.f));
        checkOutput("sb_overflow", int'(overflow), int'(mon_exp.ovf));
      end
    end
  end

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      IN     = 1'b0;
      single = 1'b0;
      run    = 1'b0;
    end
  endtask

  // One single-shot window. n counts negedges from the one that raises single;
  // IN driven at negedge n is sampled by the DUT at gate-start edge + n.
  // kind 0: square wave of period p (high in the second half); kind 1: one-cycle pulse at n == p.
  // reset_at >= 0 aborts the window with a reset at that n.
  task automatic applyStimulus(input string tag, input int kind, input int p,
                               input int reset_at, input bit extra_single,
                               input int exp_freq, input bit exp_ovf);
    int        gate_cnt;
    int        valid_n;
    sb_entry_t e;
    gate_cnt = 0;
    valid_n  = -1;
    if (reset_at < 0) begin
      e.f   = CNT_W'(exp_freq);
      e.ovf = exp_ovf;
      sb_q.push_back(e);
    end
    for (int n = 0; n < 120; n++) begin
      @(negedge CLK);
      if (reset_at >= 0 && n == reset_at + 1) begin
        checkOutput({tag, "_rst_busy"}, int'(busy), 0);
        checkOutput({tag, "_rst_gate"}, int'(gate), 0);
        checkOutput({tag, "_rst_freq"}, int'(freq), 0);
        checkOutput({tag, "_rst_ovf"}, int'(overflow), 0);
        reset  = 1'b0;
        single = 1'b0;
        IN     = 1'b0;
        break;
      end
      if (n > 0) begin
        if (gate) gate_cnt++;
        if (freq_valid && valid_n < 0) valid_n = n;
      end
      single = (n == 0) || (extra_single && (n == 30 || n == 105));
      if (kind == 0) IN = ((n % p) >= (p / 2));
      else           IN = (n == p);
      reset = (n == reset_at);
    end
    IN     = 1'b0;
    single = 1'b0;
    if (reset_at < 0) begin
      checkOutput({tag, "_gate_cycles"}, gate_cnt, GATE_CYCLES);
      checkOutput({tag, "_valid_cycle"}, valid_n, GATE_CYCLES + 2);
      checkOutput({tag, "_end_busy"}, int'(busy), 0);
    end else begin
      idleCycles(20);
      checkOutput({tag, "_after_rst_busy"}, int'(busy), 0);
    end
    idleCycles(5);
  endtask

  // Continuous mode: three windows, run dropped in the middle of the third gate.
  task automatic runContinuous();
    int        rises[4];
    int        n_rise;
    int        n_valid;
    bit        prev_gate;
    sb_entry_t e;
    n_rise    = 0;
    n_valid   = 0;
    prev_gate = 1'b0;
    e.f   = CNT_W'(10);
    e.ovf = 1'b0;
    for (int k = 0; k < 3; k++) sb_q.push_back(e);
    for (int n = 0; n < 360; n++) begin
      @(negedge CLK);
      if (n > 0) begin
        if (gate && !prev_gate) begin
          if (n_rise < 4) rises[n_rise] = n;
          n_rise++;
        end
        if (freq_valid) n_valid++;
        prev_gate = gate;
      end
      run = (n < 273);
      IN  = ((n % 10) >= 5);
    end
    run = 1'b0;
    IN  = 1'b0;
    checkOutput("cont_gate_rises", n_rise, 3);
    checkOutput("cont_first_rise", rises[0], 1);
    checkOutput("cont_period_1", rises[1] - rises[0], GATE_CYCLES + 1 + HOLD_CYCLES);
    checkOutput("cont_period_2", rises[2] - rises[1], GATE_CYCLES + 1 + HOLD_CYCLES);
    checkOutput("cont_valids", n_valid, 3);
    checkOutput("cont_end_busy", int'(busy), 0);
    idleCycles(5);
  endtask

  initial begin
    int stray;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    IN     = 1'b0;
    run    = 1'b0;
    single = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("reset_freq", int'(freq), 0);
    checkOutput("reset_overflow", int'(overflow), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_gate", int'(gate), 0);
    checkOutput("reset_valid", int'(freq_valid), 0);
    reset = 1'b0;

    // Idle with IN low: nothing may start.
    stray = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (busy || gate || freq_valid) stray++;
    end
    checkOutput("idle_activity", stray, 0);
    checkOutput("idle_freq", int'(freq), 0);

    $display("[TB] single window, IN period 10");
    applyStimulus("sq10", 0, 10, -1, 1'b0, 10, 1'b0);
    $display("[TB] single window, IN period 2 (saturates)");
    applyStimulus("sq2", 0, 2, -1, 1'b0, MAX_COUNT, 1'b1);
    applyStimulus("sq10b", 0, 10, -1, 1'b0, 10, 1'b0);
    $display("[TB] continuous mode");
    runContinuous();
    $display("[TB] reset mid-gate");
    applyStimulus("rst", 0, 10, 50, 1'b0, 0, 1'b0);
    applyStimulus("extra_single", 0, 10, -1, 1'b1, 10, 1'b0);
    $display("[TB] window boundary edges");
    applyStimulus("last_gate_edge", 1, 98, -1, 1'b0, 1, 1'b0);
    applyStimulus("latch_edge", 1, 99, -1, 1'b0, 0, 1'b0);

    checkOutput("sb_pending", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
